// File: rtl/inst_fetch_if.sv
// rtl/inst_fetch_if.sv - instruction memory request/ack bus between fetch and memory
interface inst_fetch_if;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_ack_i;
    logic [31:0] inst_rdata_i;

    modport master (
        output inst_req_o,
        output inst_addr_o,
        input  inst_ack_i,
        input  inst_rdata_i
    );

    modport slave (
        input  inst_req_o,
        input  inst_addr_o,
        output inst_ack_i,
        output inst_rdata_i
    );
endinterface

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - PC/fetch stage with one outstanding request; INST_FETCH_ALIGN_CHECK_EN adds if_adel_o
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush_i,
    input  logic [31:0]         new_pc_i,
    input  logic                branch_flag_i,
    input  logic [31:0]         branch_target_address_i,
    inst_fetch_if.master        bus,
    output logic [31:0]         if_pc_o,
    output logic [31:0]         if_inst_o,
    output logic                stallreq_if_o
`ifdef INST_FETCH_ALIGN_CHECK_EN
    ,
    output logic                if_adel_o
`endif
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, DISCARD} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] hold_buf;
    logic [31:0] pend_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] seq_pc;
    logic        misaligned;
    logic        unused_stall;

    function automatic logic [31:0] load_pc(input logic [31:0] a);
`ifdef INST_FETCH_ALIGN_CHECK_EN
        return a;
`else
        return a & 32'hFFFF_FFFC;
`endif
    endfunction

    assign unused_stall = ^stall[5:1];

    // Flush is unconditional; a branch only counts when the PC stage is not held.
    assign redirect    = flush_i | (branch_flag_i & ~stall[0]);
    assign redirect_pc = load_pc(flush_i ? new_pc_i : branch_target_address_i);
    assign seq_pc      = load_pc(pc + 32'd4);

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign misaligned = (pc[1:0] != 2'b00);
`else
    assign misaligned = 1'b0;
`endif

    assign bus.inst_addr_o = pc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            pc       <= load_pc(RESET_PC);
            hold_buf <= 32'h0;
            pend_pc  <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect) pc <= redirect_pc;
                end
                REQ: begin
                    if (misaligned) begin
                        if (flush_i) pc <= load_pc(new_pc_i);
                    end else if (bus.inst_ack_i) begin
                        if (redirect) begin
                            pc <= redirect_pc;
                        end else if (!stall[0]) begin
                            pc <= seq_pc;
                        end else begin
                            hold_buf <= bus.inst_rdata_i;
                            state    <= HOLD;
                        end
                    end else if (redirect) begin
                        // The request stays on the bus; its data is thrown away on ack.
                        pend_pc <= redirect_pc;
                        state   <= DISCARD;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc       <= redirect_pc;
                        hold_buf <= 32'h0;
                        state    <= REQ;
                    end else if (!stall[0]) begin
                        pc    <= seq_pc;
                        state <= REQ;
                    end
                end
                DISCARD: begin
                    if (redirect) pend_pc <= redirect_pc;
                    if (bus.inst_ack_i) begin
                        pc    <= redirect ? redirect_pc : pend_pc;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Outputs are forced low while rst is asserted so a reset drops any live request at once.
    always_comb begin
        bus.inst_req_o = 1'b0;
        if_pc_o        = 32'h0;
        if_inst_o      = 32'h0;
        stallreq_if_o  = 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
        if_adel_o      = 1'b0;
`endif
        if (rst) begin
            case (state)
                REQ: begin
                    if_pc_o = pc;
                    if (misaligned) begin
`ifdef INST_FETCH_ALIGN_CHECK_EN
                        if_adel_o = 1'b1;
`endif
                    end else begin
                        bus.inst_req_o = 1'b1;
                        stallreq_if_o  = ~bus.inst_ack_i;
                        if (bus.inst_ack_i && !redirect) if_inst_o = bus.inst_rdata_i;
                    end
                end
                HOLD: begin
                    if_pc_o   = pc;
                    if_inst_o = hold_buf;
                end
                DISCARD: begin
                    bus.inst_req_o = 1'b1;
                    if_pc_o        = pc;
                    stallreq_if_o  = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed and randomized checks of inst_fetch against a transaction-level model
module tb_inst_fetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush_i;
    logic [31:0] new_pc_i;
    logic        branch_flag_i;
    logic [31:0] branch_target_address_i;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;
    logic        stallreq_if_o;
`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic        if_adel_o;
`endif

    inst_fetch_if bus ();

    always #5 clk = ~clk;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .stall                   (stall),
        .flush_i                 (flush_i),
        .new_pc_i                (new_pc_i),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .bus                     (bus),
        .if_pc_o                 (if_pc_o),
        .if_inst_o               (if_inst_o),
        .stallreq_if_o           (stallreq_if_o)
`ifdef INST_FETCH_ALIGN_CHECK_EN
        ,
        .if_adel_o               (if_adel_o)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Model: a fetch is either not started, dropping a redirected request, holding a word, or active.
    logic        m_started, m_dropping, m_held;
    logic [31:0] m_pc, m_hw, m_pend;

    logic        seen_req, seen_stl;
    logic [31:0] seen_addr, seen_inst, seen_pc;

    function automatic logic [31:0] word_pc(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

    task automatic step(input logic r, input logic [5:0] st, input logic fl, input logic [31:0] np,
                        input logic br, input logic [31:0] bt, input logic ack, input logic [31:0] rd);
        logic        e_req, e_stl, chk_addr, chk_pc, redir;
        logic [31:0] e_inst, e_pc, tgt;
        @(negedge clk);
        rst = r; stall = st; flush_i = fl; new_pc_i = np;
        branch_flag_i = br; branch_target_address_i = bt;
        bus.inst_ack_i = ack; bus.inst_rdata_i = rd;
        #1;
        redir = fl | (br & ~st[0]);
        tgt   = word_pc(fl ? np : bt);
        e_req = 1'b0; e_stl = 1'b0; e_inst = 32'h0; e_pc = 32'h0;
        chk_addr = 1'b0; chk_pc = 1'b1;
        if (r && m_started) begin
            if (m_dropping) begin
                e_req = 1'b1; e_stl = 1'b1; chk_addr = 1'b1; chk_pc = 1'b0;
            end else if (m_held) begin
                e_inst = m_hw; e_pc = m_pc;
            end else begin
                e_req = 1'b1; e_stl = ~ack; chk_addr = 1'b1;
                if (ack) begin
                    e_pc = m_pc;
                    if (!redir) e_inst = rd;
                end else begin
                    chk_pc = 1'b0;
                end
            end
        end
        check("inst_req", {31'h0, bus.inst_req_o}, {31'h0, e_req});
        check("stallreq", {31'h0, stallreq_if_o}, {31'h0, e_stl});
        check("if_inst", if_inst_o, e_inst);
        if (chk_pc) check("if_pc", if_pc_o, e_pc);
        if (chk_addr) check("inst_addr", bus.inst_addr_o, m_pc);
        seen_req = bus.inst_req_o; seen_stl = stallreq_if_o;
        seen_addr = bus.inst_addr_o; seen_inst = if_inst_o; seen_pc = if_pc_o;
        @(posedge clk);
        if (!r) begin
            m_started = 1'b0; m_dropping = 1'b0; m_held = 1'b0;
            m_pc = 32'h0; m_hw = 32'h0; m_pend = 32'h0;
        end else if (!m_started) begin
            m_started = 1'b1;
            if (redir) m_pc = tgt;
        end else if (m_dropping) begin
            if (redir) m_pend = tgt;
            if (ack) begin
                m_pc = redir ? tgt : m_pend;
                m_dropping = 1'b0;
            end
        end else if (m_held) begin
            if (redir) begin
                m_pc = tgt; m_held = 1'b0; m_hw = 32'h0;
            end else if (!st[0]) begin
                m_pc = m_pc + 32'd4; m_held = 1'b0;
            end
        end else if (ack) begin
            if (redir) m_pc = tgt;
            else if (!st[0]) m_pc = m_pc + 32'd4;
            else begin m_held = 1'b1; m_hw = rd; end
        end else if (redir) begin
            m_dropping = 1'b1; m_pend = tgt;
        end
    endtask

    task automatic go(input logic ack, input logic [31:0] rd);
        step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, ack, rd);
    endtask

    initial begin
        logic [31:0] w;
        m_started = 1'b0; m_dropping = 1'b0; m_held = 1'b0;
        m_pc = 32'h0; m_hw = 32'h0; m_pend = 32'h0;

        step(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h1234);
        check("rst_req", {31'h0, seen_req}, 32'h0);
        go(1'b1, 32'hAAAA_0000);
        check("idle_stallreq", {31'h0, seen_stl}, 32'h0);
        check("idle_inst", seen_inst, 32'h0);

        for (int i = 0; i < 4; i++) begin
            go(1'b1, $urandom);
            check("seq_addr", seen_addr, 32'(i * 4));
            check("seq_stallreq", {31'h0, seen_stl}, 32'h0);
        end

        for (int i = 0; i < 3; i++) begin
            go(1'b0, 32'h0);
            check("wait_addr", seen_addr, 32'h10);
            check("wait_stallreq", {31'h0, seen_stl}, 32'h1);
        end
        go(1'b1, 32'hCAFE_0010);
        check("late_word", seen_inst, 32'hCAFE_0010);

        for (int i = 0; i < 3; i++) go(1'b1, $urandom);
        step(1'b1, 6'h1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hBEEF_0020);
        check("hold_addr", seen_addr, 32'h20);
        step(1'b1, 6'h1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hold_noreq", {31'h0, seen_req}, 32'h0);
        check("hold_word", seen_inst, 32'hBEEF_0020);
        step(1'b1, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("hold_release_noreq", {31'h0, seen_req}, 32'h0);
        go(1'b1, $urandom);
        check("after_hold_addr", seen_addr, 32'h24);

        for (int i = 0; i < 6; i++) go(1'b1, $urandom);
        step(1'b1, 6'h0, 1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 32'h0);
        check("br_pending_addr", seen_addr, 32'h40);
        go(1'b0, 32'h0);
        check("discard_addr", seen_addr, 32'h40);
        check("discard_stallreq", {31'h0, seen_stl}, 32'h1);
        go(1'b1, 32'hDEAD_0040);
        check("discard_drop", seen_inst, 32'h0);
        go(1'b1, $urandom);
        check("branch_addr", seen_addr, 32'h100);

        step(1'b1, 6'h0, 1'b1, 32'h180, 1'b1, 32'h200, 1'b1, 32'h5555_5555);
        check("redir_ack_drop", seen_inst, 32'h0);
        go(1'b1, $urandom);
        check("flush_prio_addr", seen_addr, 32'h180);
        step(1'b1, 6'h1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
        go(1'b1, $urandom);
        check("top_addr", seen_addr, 32'hFFFF_FFFC);
        go(1'b1, $urandom);
        check("wrap_addr", seen_addr, 32'h0);

        step(1'b0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        check("midreq_rst_req", {31'h0, seen_req}, 32'h0);
        go(1'b1, 32'h7777_7777);
        check("rst_ack_ignored", seen_inst, 32'h0);
        go(1'b1, $urandom);
        check("restart_addr", seen_addr, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            w = $urandom;
            step($urandom_range(0, 59) != 0,
                 {5'($urandom), $urandom_range(0, 3) == 0},
                 $urandom_range(0, 19) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00},
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 3) == 0) ? $urandom : {$urandom_range(0, 255), 2'b00},
                 $urandom_range(0, 1) == 1,
                 w);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-low reset: rst==0 sampled at rising edge resets the block.
REQ-004 stall  input  6  pipeline stall vector; only stall[0] (PC stage hold) is used.
REQ-005 flush_i  input  1  exception flush; redirect to new_pc_i.
REQ-006 new_pc_i  input  32  exception handler address.
REQ-007 branch_flag_i  input  1  taken branch from decode.
REQ-008 branch_target_address_i  input  32  branch target.
REQ-009 inst_req_o  output  1  instruction memory request.
REQ-010 inst_addr_o  output  32  fetch address; equals internal pc.
REQ-011 inst_ack_i  input  1  memory ack; inst_rdata_i valid in the same cycle.
REQ-012 inst_rdata_i  input  32  fetched instruction word.
REQ-013 if_pc_o  output  32  PC presented to the IF/ID register.
REQ-014 if_inst_o  output  32  instruction presented to IF/ID; 32'h0 (NOP) when not valid.
REQ-015 stallreq_if_o  output  1  fetch-not-ready stall request to the pipeline controller.

Function
REQ-016 FSM states SHALL be IDLE, REQ, HOLD, DISCARD.
REQ-017 IDLE: one cycle after reset release; req=0, if_inst_o=0, if_pc_o=0, stallreq_if_o=0; next REQ.
REQ-018 REQ: inst_req_o=1, inst_addr_o=pc held stable until ack sampled; stallreq_if_o=~inst_ack_i.
REQ-019 REQ with ack: if_inst_o=inst_rdata_i and if_pc_o=pc combinationally, giving zero-bubble fetch.
REQ-020 REQ with ack and stall[0]==0: pc<=next_pc, stay REQ; with stall[0]==1: capture word into hold buffer, go HOLD.
REQ-021 HOLD: inst_req_o=0, if_inst_o=buffer, if_pc_o=pc, stallreq_if_o=0; on stall[0]==0: pc<=next_pc, go REQ.
REQ-022 next_pc priority: flush_i -> new_pc_i; else branch_flag_i -> branch_target_address_i; else pc+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
REQ-023 flush_i SHALL be honoured in every state regardless of stall; branch_flag_i only in a cycle with stall[0]==0.
REQ-024 Redirect in REQ without ack: store target in pending register, go DISCARD; address held unchanged.
REQ-025 DISCARD: inst_req_o=1 (old address), if_inst_o=0, stallreq_if_o=1; on ack drop data, pc<=pending, go REQ.
REQ-026 Redirect arriving in DISCARD overwrites pending target; flush beats branch when both arrive in the same cycle.
REQ-027 Redirect coinciding with ack in REQ: returned word dropped (if_inst_o=0), pc<=target, stay REQ.
REQ-028 Redirect in HOLD: buffer dropped, pc<=target, go REQ.
REQ-029 At most one outstanding memory request at any time.

Reset
REQ-030 While rst==0: pc<=RESET_PC, state<=IDLE, hold buffer and pending register <=0, inst_req_o=0, if_pc_o=0, if_inst_o=0, stallreq_if_o=0.
REQ-031 Reset asserted mid-request SHALL abandon the request immediately, and any ack in the following cycle SHALL be ignored.

Configuration
REQ-032 Macro INST_FETCH_ALIGN_CHECK_EN: when defined, output port if_adel_o (1 bit) is added; a pc with pc[1:0]!=0 issues no request, behaves as HOLD with if_inst_o=0 and if_adel_o=1, and leaves only on flush_i; if_adel_o=0 otherwise and in reset.
REQ-033 Without INST_FETCH_ALIGN_CHECK_EN: port absent; bits [1:0] of every loaded pc are forced to 2'b00.

Verification
REQ-034 Reset release, ack every cycle, stall=0 -> addresses 0,4,8,C on consecutive cycles, stallreq_if_o=0 after IDLE.
REQ-035 Ack delayed 3 cycles at pc=0x10 -> inst_addr_o stable at 0x10 and stallreq_if_o=1 for 3 cycles, then word delivered.
REQ-036 stall[0]=1 for 2 cycles with ack at pc=0x20 -> word held in HOLD, no new request, then pc=0x24 requested.
REQ-037 Branch to 0x100 while 0x40 is pending without ack -> DISCARD, 0x40 data dropped on ack, next request at 0x100.
REQ-038 flush_i with new_pc_i=0x180 and branch_flag_i in the same cycle -> next request at 0x180; pc 0xFFFF_FFFC advances to 0x0.
